// File: rtl/aclock_multi.sv
// aclock_multi: 24 h BCD real-time clock with NUM_ALARMS alarm channels.
// Optional snooze: define ACLOCK_MULTI_SNOOZE_EN.
`timescale 1ns/1ps
module aclock_multi #(
    parameter int CLK_DIV    = 10,
    parameter int NUM_ALARMS = 4,
    parameter int SEL_W      = 2,
    parameter int SNOOZE_MIN = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            H_in1,
    input  logic [3:0]            H_in0,
    input  logic [3:0]            M_in1,
    input  logic [3:0]            M_in0,
    input  logic                  LD_time,
    input  logic                  LD_alarm,
    input  logic [SEL_W-1:0]      AL_SEL,
    input  logic [NUM_ALARMS-1:0] AL_ON,
    input  logic [NUM_ALARMS-1:0] STOP_al,
`ifdef ACLOCK_MULTI_SNOOZE_EN
    input  logic [NUM_ALARMS-1:0] snooze,
`endif
    output logic [NUM_ALARMS-1:0] Alarm,
    output logic                  Alarm_any,
    output logic                  load_err,
    output logic                  tick_1s,
    output logic [1:0]            H_out1,
    output logic [3:0]            H_out0,
    output logic [3:0]            M_out1,
    output logic [3:0]            M_out0,
    output logic [3:0]            S_out1,
    output logic [3:0]            S_out0
);

    localparam int DW = $clog2(CLK_DIV);

    logic [DW-1:0]         r_div;
    logic [1:0]            r_h1;
    logic [3:0]            r_h0;
    logic [3:0]            r_m1;
    logic [3:0]            r_m0;
    logic [3:0]            r_s1;
    logic [3:0]            r_s0;
    logic [13:0]           r_alm [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] r_alarm;
    logic                  r_adv;
    logic                  r_err;

    logic                  w_tick;
    logic                  w_valid;
    logic                  w_sel_ok;
    logic                  w_ld_time;
    logic                  w_ld_al;
    logic                  w_adv;
    logic [NUM_ALARMS-1:0] w_match;
    logic [NUM_ALARMS-1:0] w_ld_ch;

`ifdef ACLOCK_MULTI_SNOOZE_EN
    localparam logic [11:0] SNZ_LD = 12'(SNOOZE_MIN * 60);
    logic [11:0] r_snz [NUM_ALARMS];
`endif

    assign w_tick = (r_div == DW'(CLK_DIV - 1));

    assign w_valid = (H_in1 <= 2'd2) && (H_in0 <= 4'd9)
                  && ((H_in1 != 2'd2) || (H_in0 <= 4'd3))
                  && (M_in1 <= 4'd5) && (M_in0 <= 4'd9);

    assign w_sel_ok  = (32'(AL_SEL) < NUM_ALARMS);
    assign w_ld_time = LD_time && w_valid;
    assign w_ld_al   = LD_alarm && w_valid && w_sel_ok;
    // Any LD_time cycle, valid or not, suppresses the tick.
    assign w_adv     = w_tick && !LD_time;

    always_comb begin
        w_match = '0;
        w_ld_ch = '0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            w_match[i] = (r_alm[i] == {r_h1, r_h0, r_m1, r_m0})
                      && (r_s1 == 4'd0) && (r_s0 == 4'd0);
            w_ld_ch[i] = w_ld_al && (32'(AL_SEL) == i);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div <= '0;
        end else if (w_ld_time || w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_h1 <= '0;
            r_h0 <= '0;
            r_m1 <= '0;
            r_m0 <= '0;
            r_s1 <= '0;
            r_s0 <= '0;
        end else if (w_ld_time) begin
            r_h1 <= H_in1;
            r_h0 <= H_in0;
            r_m1 <= M_in1;
            r_m0 <= M_in0;
            r_s1 <= '0;
            r_s0 <= '0;
        end else if (w_adv) begin
            if (r_s0 != 4'd9) begin
                r_s0 <= r_s0 + 4'd1;
            end else begin
                r_s0 <= '0;
                if (r_s1 != 4'd5) begin
                    r_s1 <= r_s1 + 4'd1;
                end else begin
                    r_s1 <= '0;
                    if (r_m0 != 4'd9) begin
                        r_m0 <= r_m0 + 4'd1;
                    end else begin
                        r_m0 <= '0;
                        if (r_m1 != 4'd5) begin
                            r_m1 <= r_m1 + 4'd1;
                        end else begin
                            r_m1 <= '0;
                            if (r_h1 == 2'd2 && r_h0 == 4'd3) begin
                                r_h1 <= '0;
                                r_h0 <= '0;
                            end else if (r_h0 == 4'd9) begin
                                r_h0 <= '0;
                                r_h1 <= r_h1 + 2'd1;
                            end else begin
                                r_h0 <= r_h0 + 4'd1;
                            end
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_adv <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_adv <= w_adv;
            r_err <= ((LD_time || LD_alarm) && !w_valid)
                  || (LD_alarm && !w_sel_ok);
        end
    end

    // Per channel: stop/disable, then reload, then snooze, then set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_alarm <= '0;
            for (int i = 0; i < NUM_ALARMS; i++) begin
                r_alm[i] <= '0;
`ifdef ACLOCK_MULTI_SNOOZE_EN
                r_snz[i] <= '0;
`endif
            end
        end else begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                if (w_ld_ch[i]) begin
                    r_alm[i] <= {H_in1, H_in0, M_in1, M_in0};
                end
`ifdef ACLOCK_MULTI_SNOOZE_EN
                if (STOP_al[i] || !AL_ON[i] || w_ld_ch[i]) begin
                    r_alarm[i] <= 1'b0;
                    r_snz[i]   <= '0;
                end else if (snooze[i] && r_alarm[i]) begin
                    r_alarm[i] <= 1'b0;
                    r_snz[i]   <= SNZ_LD;
                end else begin
                    if (w_adv && r_snz[i] != '0) begin
                        r_snz[i] <= r_snz[i] - 12'd1;
                    end
                    if ((w_adv && r_snz[i] == 12'd1)
                        || (r_adv && w_match[i])) begin
                        r_alarm[i] <= 1'b1;
                    end
                end
`else
                if (STOP_al[i] || !AL_ON[i] || w_ld_ch[i]) begin
                    r_alarm[i] <= 1'b0;
                end else if (r_adv && w_match[i]) begin
                    r_alarm[i] <= 1'b1;
                end
`endif
            end
        end
    end

    assign Alarm     = r_alarm;
    assign Alarm_any = |r_alarm;
    assign load_err  = r_err;
    assign tick_1s   = w_tick;
    assign H_out1    = r_h1;
    assign H_out0    = r_h0;
    assign M_out1    = r_m1;
    assign M_out0    = r_m0;
    assign S_out1    = r_s1;
    assign S_out0    = r_s0;

endmodule

// File: doc/aclock_multi.md
Name: aclock_multi

Overview:
- Parametrised successor to the single-alarm clock: 24 h BCD real-time clock with NUM_ALARMS independent alarm channels.
- Runs entirely in the system `clk` domain. The 1 s tick is a one-cycle enable from a CLK_DIV prescaler; no derived clock.
- Used as the timekeeping/alarm peripheral of the microcontroller. Adds input validation, per-channel alarm control and an optional snooze.

Parameters:
- CLK_DIV, 10: clk cycles per real-time second; must be >= 2.
- NUM_ALARMS, 4: number of alarm channels, 1..16.
- SEL_W, 2: width of AL_SEL; must satisfy 2**SEL_W >= NUM_ALARMS.
- SNOOZE_MIN, 5: snooze length in minutes, 1..59; used only with SNOOZE_EN.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- H_in1  in  2  hour tens digit to load.
- H_in0  in  4  hour units digit to load.
- M_in1  in  4  minute tens digit to load.
- M_in0  in  4  minute units digit to load.
- LD_time  in  1  load clock from H_in*/M_in.
- LD_alarm  in  1  load alarm channel AL_SEL from H_in*/M_in.
- AL_SEL  in  SEL_W  alarm channel for LD_alarm.
- AL_ON  in  NUM_ALARMS  per-channel alarm enable.
- STOP_al  in  NUM_ALARMS  per-channel alarm stop, level.
- Alarm  out  NUM_ALARMS  per-channel sticky alarm flag.
- Alarm_any  out  1  OR of Alarm.
- load_err  out  1  one-cycle pulse when a load was rejected.
- tick_1s  out  1  one-cycle pulse per second.
- H_out1  out  2  hour tens digit.
- H_out0  out  4  hour units digit.
- M_out1  out  4  minute tens digit.
- M_out0  out  4  minute units digit.
- S_out1  out  4  second tens digit.
- S_out0  out  4  second units digit.

Behaviour:
Reset (reset=0, async):
- Clock time = 00:00:00.
- Every alarm register = 00:00.
- Prescaler = 0; Alarm = 0, tick_1s = 0, load_err = 0.
- Snooze counters idle.
- All state is registered, so every output is 0 during and immediately after reset.

Prescaler:
- Counts 0..CLK_DIV-1 and wraps.
- tick_1s is high for exactly the cycle in which the count equals CLK_DIV-1, i.e. period CLK_DIV cycles.
- The first tick after reset release or after a valid LD_time occurs CLK_DIV cycles later.

Timekeeping:
- Time is held directly as BCD digits; no binary-to-BCD conversion.
- On tick_1s with LD_time=0, seconds increment. Carries ripple S0 9->0, S1 5->0, M0 9->0, M1 5->0; hours roll 23->00, giving 23:59:59 -> 00:00:00.
- Outputs are driven straight from the digit registers.

Load validation:
- A load is valid only if H_in1 <= 2, H_in0 <= 9, hour value <= 23, M_in1 <= 5 and M_in0 <= 9.
- Invalid load: registers unchanged, load_err pulses high for 1 cycle.

LD_time:
- Sampled every clk. If valid, sets HH:MM from the inputs, seconds = 00, prescaler = 0.
- Takes priority over a tick in the same cycle.
- While LD_time is held high the time stays frozen at HH:MM:00.

LD_alarm:
- If valid, loads alarm[AL_SEL] = HH:MM and clears Alarm[AL_SEL].
- AL_SEL >= NUM_ALARMS is ignored and treated as an error (load_err pulses).
- LD_time and LD_alarm together are allowed: both act on the same inputs; load_err pulses once if the inputs are invalid.

Match:
- A registered strobe fires one cycle after each tick that actually advanced time.
- On that strobe, for each channel i: if time == alarm[i]:00 and AL_ON[i]=1, Alarm[i] is set on the next cycle.
  - Latency is 2 cycles from tick_1s.
- Loading a time equal to an alarm does not fire: seconds have moved past 00 by the next strobe.

Clear priority, per channel, highest first:
1. reset.
2. STOP_al[i]=1 or AL_ON[i]=0: Alarm[i] held 0. This beats a same-cycle set.
3. LD_alarm to channel i.
4. Set on match.
- Otherwise Alarm[i] holds (sticky).

Alarm_any: combinational OR of the Alarm registers.

Optional Feature:
- Macro: ACLOCK_MULTI_SNOOZE_EN.
- Defined:
  - Adds input port `snooze`, width NUM_ALARMS.
  - snooze[i]=1 while Alarm[i]=1 clears Alarm[i] and loads a per-channel down-counter with SNOOZE_MIN*60.
  - The counter decrements on each time-advancing tick.
  - On 1->0, Alarm[i] re-asserts if AL_ON[i]=1.
  - STOP_al[i], AL_ON[i]=0, LD_alarm to channel i and reset cancel the snooze.
  - snooze while Alarm[i]=0 is ignored. Re-snooze reloads the counter.
- Undefined: no `snooze` port, no counters; behaviour exactly as above.

Test Plan:
- Reset release, CLK_DIV=10, no loads -> tick_1s every 10 cycles; after 10 ticks the outputs show 00:00:10.
- LD_time 23:59, wait 61 ticks -> outputs 00:00:01 after the rollover; tick_1s first seen 10 cycles after LD_time drops.
- LD_time with H_in1=2, H_in0=5 (hour 25) and, separately, M_in1=6 -> load_err pulses once each; time unchanged.
- LD_alarm ch2 = 08:00, AL_ON=4'b0100, LD_time 07:59, 60 ticks -> Alarm=4'b0100 two cycles after the 08:00:00 tick. Then STOP_al[2] -> Alarm=0 next cycle.
- Two channels at 12:30, only AL_ON[0]=1; STOP_al[0] asserted in the set cycle -> Alarm stays 0 (stop wins). AL_ON drop on another channel clears its flag.
- With ACLOCK_MULTI_SNOOZE_EN, SNOOZE_MIN=1: alarm fires, snooze pulse -> Alarm low; re-asserts after exactly 60 ticks. STOP_al during snooze -> never re-asserts.
